alu_instr_encoder: RTL and testbench

- Inverse of the datapath's ALU decode step: accepts an abstract ALU request (ALUop code, register numbers, optional 16-bit immediate) and emits legal MIPS32 instruction words.
- Encodings follow Opcode.vh (opcode/funct) and ALUop.vh (op codes).
- Feeds the on-chip self-test sequencer and instruction-memory loader.
- Valid/ready on both sides. Immediate forms with no native I-type are expanded into a two-word sequence through $at ($1).

---
 rtl/alu_instr_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_alu_instr_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_encoder.sv
// ALU request to MIPS32 instruction word encoder with valid/ready on both sides.
// ALU_ENC_EXPAND_EN enables the two-word SUBU/NOR immediate expansion via AT_REG.
module alu_instr_encoder #(
  parameter logic [4:0] AT_REG = 5'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err
);

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

`ifdef ALU_ENC_EXPAND_EN
  typedef enum logic [1:0] {
    S_IDLE, S_EMIT0, S_EMIT1, S_ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EMIT0, S_ERR
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        enc_ok;
  logic [31:0] enc_w0;
  logic [5:0]  funct;
  logic        accept;
`ifdef ALU_ENC_EXPAND_EN
  logic [31:0] enc_w1;
  logic        enc_exp;
  logic [31:0] w1_q, w1_d;
  logic        last_q, last_d;
`endif

`ifdef ALU_ENC_EXPAND_EN
  assign out_valid = (state_q == S_EMIT0) |
                     (state_q == S_EMIT1);
  assign out_last  = last_q;
`else
  assign out_valid = (state_q == S_EMIT0);
  assign out_last  = 1'b1;
`endif
  assign out_instr = instr_q;
  assign err       = (state_q == S_ERR);
  assign in_ready  = !out_valid | (out_ready & out_last);
  assign accept    = in_valid & in_ready;

  // Translate the abstract request into word0 (and word1 when expanding).
  always_comb begin
    enc_ok  = 1'b1;
    enc_w0  = '0;
    funct   = F_SLL;
`ifdef ALU_ENC_EXPAND_EN
    enc_w1  = '0;
    enc_exp = 1'b0;
`endif
    if (!in_use_imm) begin
      case (in_aluop)
        ALU_ADDU: funct = F_ADDU;
        ALU_SUBU: funct = F_SUBU;
        ALU_AND:  funct = F_AND;
        ALU_OR:   funct = F_OR;
        ALU_XOR:  funct = F_XOR;
        ALU_NOR:  funct = F_NOR;
        ALU_SLT:  funct = F_SLT;
        ALU_SLTU: funct = F_SLTU;
        ALU_SLL:  funct = F_SLLV;
        ALU_SRL:  funct = F_SRLV;
        ALU_SRA:  funct = F_SRAV;
        default:  enc_ok = 1'b0;
      endcase
      enc_w0 = {OP_SPECIAL, in_rs, in_rt,
                in_rd, 5'd0, funct};
    end else begin
      case (in_aluop)
        ALU_ADDU: enc_w0 = {OP_ADDIU, in_rs, in_rd, in_imm};
        ALU_AND:  enc_w0 = {OP_ANDI, in_rs, in_rd, in_imm};
        ALU_OR:   enc_w0 = {OP_ORI, in_rs, in_rd, in_imm};
        ALU_XOR:  enc_w0 = {OP_XORI, in_rs, in_rd, in_imm};
        ALU_SLT:  enc_w0 = {OP_SLTI, in_rs, in_rd, in_imm};
        ALU_SLTU: enc_w0 = {OP_SLTIU, in_rs, in_rd, in_imm};
        ALU_LUI:  enc_w0 = {OP_LUI, 5'd0, in_rd, in_imm};
        ALU_SLL, ALU_SRL, ALU_SRA: begin
          if (in_aluop == ALU_SLL)      funct = F_SLL;
          else if (in_aluop == ALU_SRL) funct = F_SRL;
          else                          funct = F_SRA;
          enc_ok = (in_imm[15:5] == 11'd0);
          enc_w0 = {OP_SPECIAL, 5'd0, in_rt, in_rd,
                    in_imm[4:0], funct};
        end
`ifdef ALU_ENC_EXPAND_EN
        ALU_SUBU, ALU_NOR: begin
          funct   = (in_aluop == ALU_SUBU) ? F_SUBU : F_NOR;
          enc_ok  = (in_rs != AT_REG);
          enc_exp = 1'b1;
          enc_w0  = {OP_ORI, 5'd0, AT_REG, in_imm};
          enc_w1  = {OP_SPECIAL, in_rs, AT_REG,
                     in_rd, 5'd0, funct};
        end
`endif
        default: enc_ok = 1'b0;
      endcase
    end
  end

  // Next state: second word first, then new accept, then drain to idle.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
`ifdef ALU_ENC_EXPAND_EN
    w1_d    = w1_q;
    last_d  = last_q;
    if (state_q == S_EMIT0 && out_ready && !last_q) begin
      state_d = S_EMIT1;
      instr_d = w1_q;
      last_d  = 1'b1;
    end else
`endif
    if (accept) begin
      if (enc_ok) begin
        state_d = S_EMIT0;
        instr_d = enc_w0;
`ifdef ALU_ENC_EXPAND_EN
        last_d  = !enc_exp;
        w1_d    = enc_w1;
`endif
      end else begin
        state_d = S_ERR;
      end
    end else if (state_q == S_ERR ||
                 (out_valid && out_ready)) begin
      state_d = S_IDLE;
    end
  end

  // State and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
`ifdef ALU_ENC_EXPAND_EN
      w1_q    <= '0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
`ifdef ALU_ENC_EXPAND_EN
      w1_q    <= w1_d;
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Scoreboard bench for alu_instr_encoder.
// Expected words are queued at acceptance; a monitor pops them on output.
module tb_alu_instr_encoder;

  localparam logic [3:0] ADDU = 4'd0;
  localparam logic [3:0] SUBU = 4'd1;
  localparam logic [3:0] NOR  = 4'd5;
  localparam logic [3:0] SLTU = 4'd7;
  localparam logic [3:0] SLL  = 4'd8;
  localparam logic [3:0] SRA  = 4'd10;
  localparam logic [3:0] LUI  = 4'd11;
  localparam logic [3:0] XXX  = 4'd15;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_aluop = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [15:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  alu_instr_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h",
                  name, act, req);
  endtask

  task automatic push_w(input logic [31:0] w,
                        input logic l);
    exp_t e;
    e.is_err = 1'b0;
    e.instr  = w;
    e.last   = l;
    sb.push_back(e);
  endtask

  task automatic push_e();
    exp_t e;
    e.is_err = 1'b1;
    e.instr  = '0;
    e.last   = 1'b0;
    sb.push_back(e);
  endtask

  // Present a request and hold it until accepted.
  task automatic send(input logic [3:0] op,
                      input logic [4:0] rd,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [15:0] imm,
                      input logic ui,
                      output int waited);
    in_aluop   = op;
    in_rd      = rd;
    in_rs      = rs;
    in_rt      = rt;
    in_imm     = imm;
    in_use_imm = ui;
    in_valid   = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every presented word or error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (err) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_err: got err=1 required none");
        end else begin
          e = sb.pop_front();
          chk("err_slot", 32'(e.is_err), 32'd1);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h required none",
                   out_instr);
        end else begin
          e = sb.pop_front();
          chk("word_slot", 32'(e.is_err), 32'd0);
          chk("instr", out_instr, e.instr);
          chk("last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    int w;
    int n;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef ALU_ENC_EXPAND_EN
    chk("rst_last", 32'(out_last), 32'd0);
`else
    chk("rst_last", 32'(out_last), 32'd1);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(ADDU, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0, w);
    push_w(32'h00851821, 1'b1);
    @(negedge clk);
    chk("addu_lat_valid", 32'(out_valid), 32'd1);
    chk("addu_lat_instr", out_instr, 32'h00851821);
    chk("addu_lat_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    send(ADDU, 5'd2, 5'd0, 5'd0, 16'h1234, 1'b1, w);
    push_w(32'h24021234, 1'b1);
    send(ADDU, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0, w);
    push_w(32'h00851821, 1'b1);
    chk("b2b_wait", 32'(w), 32'd0);

    send(SUBU, 5'd8, 5'd9, 5'd0, 16'h00ff, 1'b1, w);
`ifdef ALU_ENC_EXPAND_EN
    push_w(32'h340100ff, 1'b0);
    push_w(32'h01214023, 1'b1);
    @(negedge clk);
    chk("exp_ready_w0", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("exp_ready_w1", 32'(in_ready), 32'd1);
`else
    push_e();
    @(negedge clk);
    chk("subu_noexp_valid", 32'(out_valid), 32'd0);
    chk("subu_noexp_err", 32'(err), 32'd1);
`endif
    @(posedge clk);
    #1;

    send(SLL, 5'd2, 5'd0, 5'd3, 16'd4, 1'b1, w);
    push_w(32'h00031100, 1'b1);
    send(SLL, 5'd2, 5'd0, 5'd3, 16'd32, 1'b1, w);
    push_e();
    @(negedge clk);
    chk("sll32_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("sll32_err_once", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    send(LUI, 5'd7, 5'd0, 5'd0, 16'habcd, 1'b1, w);
    push_w(32'h3c07abcd, 1'b1);
    send(LUI, 5'd7, 5'd1, 5'd2, 16'h0, 1'b0, w);
    push_e();
    send(XXX, 5'd7, 5'd1, 5'd2, 16'h0, 1'b0, w);
    push_e();
    send(SRA, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0, w);
    push_w(32'h00641007, 1'b1);
    send(SLTU, 5'd5, 5'd6, 5'd0, 16'hffff, 1'b1, w);
    push_w(32'h2cc5ffff, 1'b1);
    send(NOR, 5'd4, 5'd1, 5'd0, 16'h0001, 1'b1, w);
    push_e();
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(ADDU, 5'd2, 5'd0, 5'd0, 16'h1234, 1'b1, w);
    push_w(32'h24021234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_instr", out_instr, 32'h24021234);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(out_valid), 32'd0);

`ifdef ALU_ENC_EXPAND_EN
    out_ready = 1'b0;
    send(SUBU, 5'd8, 5'd9, 5'd0, 16'h00ff, 1'b1, w);
    push_w(32'h340100ff, 1'b0);
    push_w(32'h01214023, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("emit1_instr", out_instr, 32'h01214023);
    chk("emit1_last", 32'(out_last), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
`else
    out_ready = 1'b0;
    send(ADDU, 5'd2, 5'd0, 5'd0, 16'h1234, 1'b1, w);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
`endif
    send(ADDU, 5'd3, 5'd4, 5'd5, 16'h0, 1'b0, w);
    push_w(32'h00851821, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
